// File: rtl/fsm_input_conditioner_if.sv
// Condition-input bundle between the conditioning stage and its consumer.
// Suffixes are from the conditioner's point of view (_i into it, _o out of it).
interface fsm_input_conditioner_if #(
  parameter int unsigned GLITCH_W = 8
) ();

  logic                enable_i;
  logic                raw_a_i;
  logic                raw_b_i;
  logic                glitch_clear_i;
  logic                a_o;
  logic                b_o;
  logic                a_rise_o;
  logic                b_rise_o;
  logic [GLITCH_W-1:0] glitch_count_o;

  // Driver side: raw conditions and control in, clean levels out
  modport master (
    output enable_i, raw_a_i, raw_b_i, glitch_clear_i,
    input  a_o, b_o, a_rise_o, b_rise_o, glitch_count_o
  );

  // Conditioner side
  modport slave (
    input  enable_i, raw_a_i, raw_b_i, glitch_clear_i,
    output a_o, b_o, a_rise_o, b_rise_o, glitch_count_o
  );

endinterface

// File: rtl/fsm_input_conditioner.sv
// Input conditioner: 2-flop synchronizer, per-channel debounce FSM,
// registered clean levels, one-cycle rise pulses and a saturating glitch count.
// Channel index 0 is A, index 1 is B.
module fsm_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  fsm_input_conditioner_if.slave        bus
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned SUM_W = GLITCH_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_PEND_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_PEND_LOW  = 2'd3
  } state_e;

  logic [NCH-1:0]      raw_c;
  logic [NCH-1:0]      sync1_q;
  logic [NCH-1:0]      sync2_q;
  state_e              state_q [NCH];
  state_e              state_d [NCH];
  logic [CNT_W-1:0]    cnt_q   [NCH];
  logic [CNT_W-1:0]    cnt_d   [NCH];
  logic [NCH-1:0]      lvl_q;
  logic [NCH-1:0]      lvl_d;
  logic [NCH-1:0]      rise_q;
  logic [NCH-1:0]      rise_d;
  logic [NCH-1:0]      abort_c;
  logic [SUM_W-1:0]    glitch_sum_c;
  logic [GLITCH_W-1:0] glitch_q;
  logic [GLITCH_W-1:0] glitch_d;

  assign raw_c = {bus.raw_b_i, bus.raw_a_i};

  // Two-flop synchronizer, free-running regardless of enable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state, counters, clean levels, pulses and glitch count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= ST_LOW;
        cnt_q[ch]   <= '0;
      end
      lvl_q    <= '0;
      rise_q   <= '0;
      glitch_q <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      lvl_q    <= lvl_d;
      rise_q   <= rise_d;
      glitch_q <= glitch_d;
    end
  end

  // Per-channel next state; disable forces idle without counting aborts
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      rise_d[ch]  = 1'b0;
      abort_c[ch] = 1'b0;
      if (!bus.enable_i) begin
        state_d[ch] = ST_LOW;
        cnt_d[ch]   = '0;
      end else begin
        case (state_q[ch])
          ST_LOW: begin
            if (sync2_q[ch]) begin
              state_d[ch] = ST_PEND_HIGH;
              cnt_d[ch]   = CNT_W'(1);
            end
          end
          ST_PEND_HIGH: begin
            if (!sync2_q[ch]) begin
              state_d[ch] = ST_LOW;
              cnt_d[ch]   = '0;
              abort_c[ch] = 1'b1;
            end else if (cnt_q[ch] == CNT_LAST) begin
              state_d[ch] = ST_HIGH;
              cnt_d[ch]   = '0;
              rise_d[ch]  = 1'b1;
            end else begin
              cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
            end
          end
          ST_HIGH: begin
            if (!sync2_q[ch]) begin
              state_d[ch] = ST_PEND_LOW;
              cnt_d[ch]   = CNT_W'(1);
            end
          end
          ST_PEND_LOW: begin
            if (sync2_q[ch]) begin
              state_d[ch] = ST_HIGH;
              cnt_d[ch]   = '0;
              abort_c[ch] = 1'b1;
            end else if (cnt_q[ch] == CNT_LAST) begin
              state_d[ch] = ST_LOW;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
            end
          end
          default: begin
            state_d[ch] = ST_LOW;
            cnt_d[ch]   = '0;
          end
        endcase
      end
      // Clean level is high while accepted-high, including pending fall
      lvl_d[ch] = (state_d[ch] == ST_HIGH) || (state_d[ch] == ST_PEND_LOW);
    end
  end

  // Saturating glitch accumulator; clear wins over same-cycle aborts
  always_comb begin
    glitch_sum_c = SUM_W'(glitch_q) + SUM_W'(abort_c[0]) + SUM_W'(abort_c[1]);
    glitch_d     = glitch_q;
    if (bus.glitch_clear_i) begin
      glitch_d = '0;
    end else if (glitch_sum_c[GLITCH_W]) begin
      glitch_d = '1;
    end else begin
      glitch_d = glitch_sum_c[GLITCH_W-1:0];
    end
  end

  assign bus.a_o            = lvl_q[0];
  assign bus.b_o            = lvl_q[1];
  assign bus.a_rise_o       = rise_q[0];
  assign bus.b_rise_o       = rise_q[1];
  assign bus.glitch_count_o = glitch_q;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench for fsm_input_conditioner with DEBOUNCE_CYCLES=4.
// Stimulus runs on falling edges and queues expected snapshots stamped with
// the rising-edge count; the monitor compares on each falling edge.
module tb_fsm_input_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned GW  = 8;

  typedef struct {
    int          cyc;
    logic [11:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   tests;
  int   fails;
  int   seen_a;
  int   seen_b;
  int   exp_ra;
  int   exp_rb;
  exp_t sb[$];

  fsm_input_conditioner_if #(.GLITCH_W(GW)) bus ();

  fsm_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3),
    .GLITCH_W        (GW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp expectations
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Push an expectation for the falling edge 'off' rising edges from now
  task automatic expect_at(input int off, input logic a, input logic b,
                           input logic ar, input logic br,
                           input logic [7:0] gc, input string name);
    exp_t e;
    e.cyc  = edge_cnt + off;
    e.exp  = {a, b, ar, br, gc};
    e.name = name;
    sb.push_back(e);
    if (ar) exp_ra++;
    if (br) exp_rb++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: count rise pulses and compare due snapshots
  always @(negedge clk) begin
    logic [11:0] act;
    exp_t        e;
    act = {bus.a_o, bus.b_o, bus.a_rise_o, bus.b_rise_o, bus.glitch_count_o};
    if (bus.a_rise_o === 1'b1) seen_a++;
    if (bus.b_rise_o === 1'b1) seen_b++;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      tests++;
      if (e.cyc != edge_cnt) begin
        fails++;
        $display("FAIL %s: snapshot missed (due edge %0d, now %0d)", e.name, e.cyc, edge_cnt);
      end else if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got a=%b b=%b ar=%b br=%b gc=%0d, want a=%b b=%b ar=%b br=%b gc=%0d",
                 e.name, act[11], act[10], act[9], act[8], act[7:0],
                 e.exp[11], e.exp[10], e.exp[9], e.exp[8], e.exp[7:0]);
      end
    end
  end

  initial begin
    tests  = 0;
    fails  = 0;
    seen_a = 0;
    seen_b = 0;
    exp_ra = 0;
    exp_rb = 0;
    rst                = 1'b1;
    bus.enable_i       = 1'b1;
    bus.raw_a_i        = 1'b0;
    bus.raw_b_i        = 1'b0;
    bus.glitch_clear_i = 1'b0;

    // Reset state
    step(2);
    expect_at(1, 0, 0, 0, 0, 8'd0, "reset_state");
    step(1);
    rst = 1'b0;
    step(2);

    // 1: A rises, qualifies at edge 6 with a single pulse
    bus.raw_a_i = 1'b1;
    expect_at(5, 0, 0, 0, 0, 8'd0, "t1_before_edge6");
    expect_at(6, 1, 0, 1, 0, 8'd0, "t1_rise");
    expect_at(7, 1, 0, 0, 0, 8'd0, "t1_pulse_done");
    step(8);
    bus.raw_a_i = 1'b0;
    expect_at(5, 1, 0, 0, 0, 8'd0, "t1_fall_pending");
    expect_at(6, 0, 0, 0, 0, 8'd0, "t1_fall_done");
    step(8);

    // 2: A high for two cycles only -> one glitch, no level change
    bus.raw_a_i = 1'b1;
    expect_at(4, 0, 0, 0, 0, 8'd0, "t2_pending");
    expect_at(5, 0, 0, 0, 0, 8'd1, "t2_glitch");
    step(2);
    bus.raw_a_i = 1'b0;
    step(6);

    // 3: simultaneous glitches add two in one cycle
    bus.raw_a_i = 1'b1;
    bus.raw_b_i = 1'b1;
    expect_at(5, 0, 0, 0, 0, 8'd3, "t3_dual_glitch");
    step(2);
    bus.raw_a_i = 1'b0;
    bus.raw_b_i = 1'b0;
    step(6);

    // 3b: 300 more glitches saturate the count
    for (int i = 0; i < 150; i++) begin
      bus.raw_a_i = 1'b1;
      bus.raw_b_i = 1'b1;
      step(2);
      bus.raw_a_i = 1'b0;
      bus.raw_b_i = 1'b0;
      step(3);
    end
    expect_at(1, 0, 0, 0, 0, 8'd255, "t3_saturated");
    step(2);
    bus.raw_a_i = 1'b1;
    bus.raw_b_i = 1'b1;
    expect_at(5, 0, 0, 0, 0, 8'd255, "t3_sat_holds");
    step(2);
    bus.raw_a_i = 1'b0;
    bus.raw_b_i = 1'b0;
    step(6);

    // 6: clear on the same edge as an abort wins
    bus.raw_a_i = 1'b1;
    expect_at(4, 0, 0, 0, 0, 8'd255, "t6_before_clear");
    expect_at(5, 0, 0, 0, 0, 8'd0, "t6_clear_priority");
    expect_at(6, 0, 0, 0, 0, 8'd0, "t6_after_clear");
    step(2);
    bus.raw_a_i = 1'b0;
    step(2);
    bus.glitch_clear_i = 1'b1;
    step(1);
    bus.glitch_clear_i = 1'b0;
    step(3);
    bus.raw_b_i = 1'b1;
    expect_at(5, 0, 0, 0, 0, 8'd1, "t6_count_resumes");
    step(2);
    bus.raw_b_i = 1'b0;
    step(6);

    // 4: both high, one-cycle disable drops them, then they requalify
    bus.raw_a_i = 1'b1;
    bus.raw_b_i = 1'b1;
    expect_at(6, 1, 1, 1, 1, 8'd1, "t4_both_rise");
    expect_at(7, 1, 1, 0, 0, 8'd1, "t4_both_high");
    step(8);
    bus.enable_i = 1'b0;
    expect_at(1, 0, 0, 0, 0, 8'd1, "t4_disabled");
    expect_at(4, 0, 0, 0, 0, 8'd1, "t4_requalifying");
    expect_at(5, 1, 1, 1, 1, 8'd1, "t4_return_rise");
    expect_at(6, 1, 1, 0, 0, 8'd1, "t4_return_high");
    step(1);
    bus.enable_i = 1'b1;
    step(6);
    bus.raw_a_i = 1'b0;
    bus.raw_b_i = 1'b0;
    step(8);

    // 5: async reset while A is pending clears everything mid-cycle
    bus.raw_b_i = 1'b1;
    expect_at(6, 0, 1, 0, 1, 8'd1, "t5_b_up");
    step(8);
    bus.raw_a_i = 1'b1;
    expect_at(3, 0, 1, 0, 0, 8'd1, "t5_pre_reset");
    expect_at(4, 0, 0, 0, 0, 8'd0, "t5_async_clear");
    expect_at(9, 0, 0, 0, 0, 8'd0, "t5_full_latency");
    expect_at(10, 1, 1, 1, 1, 8'd0, "t5_requalified");
    expect_at(11, 1, 1, 0, 0, 8'd0, "t5_pulse_done");
    step(3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(9);

    // Pulse totals and scoreboard drain
    tests++;
    if (seen_a != exp_ra) begin
      fails++;
      $display("FAIL a_rise_count: got %0d, want %0d", seen_a, exp_ra);
    end
    tests++;
    if (seen_b != exp_rb) begin
      fails++;
      $display("FAIL b_rise_count: got %0d, want %0d", seen_b, exp_rb);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
